// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter with a small byte FIFO.
// DATA at BASE_ADDR queues a byte; STATUS at BASE_ADDR+1 reports FIFO/line state.
module io_uart_tx #(
    parameter int          CLK_DIV   = 16,
    parameter logic [19:0] BASE_ADDR = 20'h80000,
    parameter int          DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] bus_addr,
    inout  wire  [15:0] bus_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        tx,
    output logic        tx_busy
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [19:0] STAT_ADDR = BASE_ADDR + 20'd1;
    localparam logic [15:0] RELOAD    = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_nx;
    logic [15:0]     cnt, cnt_nx;
    logic [2:0]      idx, idx_nx;
    logic [7:0]      sh, sh_nx;
    logic            tx_nx, busy_nx, pop;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [4:0]      count;
    logic            ovf;
    logic            data_hit, stat_hit, empty, full, push_req, push, stat_rd;
    logic [15:0]     rd_val;

    assign data_hit = bus_addr == BASE_ADDR;
    assign stat_hit = bus_addr == STAT_ADDR;
    assign empty    = count == 5'd0;
    assign full     = count == 5'(DEPTH);
    assign push_req = mem_write && data_hit;
    assign push     = push_req && !full;
    assign stat_rd  = mem_read && stat_hit;
    assign rd_val   = stat_hit ? {7'b0, count, ovf, tx_busy, full, empty} : 16'h0000;
    assign bus_data = (mem_read && (data_hit || stat_hit)) ? rd_val : 16'bz;

    // Every state holds for CLK_DIV cycles: cnt is reloaded at each bit boundary.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        sh_nx    = sh;
        tx_nx    = tx;
        busy_nx  = tx_busy;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    sh_nx    = mem[rd_ptr];
                    tx_nx    = 1'b0;
                    busy_nx  = 1'b1;
                    cnt_nx   = RELOAD;
                    state_nx = START;
                end
            end
            START: begin
                if (cnt != 16'd0) begin
                    cnt_nx = cnt - 16'd1;
                end else begin
                    cnt_nx   = RELOAD;
                    tx_nx    = sh[0];
                    sh_nx    = {1'b0, sh[7:1]};
                    idx_nx   = 3'd0;
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (cnt != 16'd0) begin
                    cnt_nx = cnt - 16'd1;
                end else begin
                    cnt_nx   = RELOAD;
                    tx_nx    = (idx == 3'd7) ? 1'b1 : sh[0];
                    sh_nx    = {1'b0, sh[7:1]};
                    idx_nx   = (idx == 3'd7) ? 3'd0 : idx + 3'd1;
                    state_nx = (idx == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                if (cnt != 16'd0) begin
                    cnt_nx = cnt - 16'd1;
                end else if (!empty) begin
                    // Chain straight into the next start bit so frames abut.
                    pop      = 1'b1;
                    sh_nx    = mem[rd_ptr];
                    tx_nx    = 1'b0;
                    cnt_nx   = RELOAD;
                    state_nx = START;
                end else begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            idx     <= 3'd0;
            sh      <= 8'd0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= 5'd0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            sh      <= sh_nx;
            tx      <= tx_nx;
            tx_busy <= busy_nx;
            wr_ptr  <= wr_ptr + AW'(push);
            rd_ptr  <= rd_ptr + AW'(pop);
            count   <= count + 5'(push) - 5'(pop);
            ovf     <= (push_req && full) ? 1'b1 : stat_rd ? 1'b0 : ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus_data[7:0];
    end
endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: directed and random bus traffic checked against a frame-level line model.
module tb_io_uart_tx;
    localparam int          D     = 4;
    localparam int          N     = 4;
    localparam logic [19:0] BASE  = 20'h80000;
    localparam logic [19:0] STAT  = BASE + 20'd1;
    localparam logic [15:0] FLOAT = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] bus_addr = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        tx, tx_busy;
    logic [15:0] drv = '0;
    logic        drv_en = 1'b0;
    tri1  [15:0] bus_data;

    assign bus_data = drv_en ? drv : 16'bz;

    always #5 clk = ~clk;

    io_uart_tx #(.CLK_DIV(D), .BASE_ADDR(BASE), .DEPTH(N)) dut (
        .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_data(bus_data),
        .mem_read(mem_read), .mem_write(mem_write), .tx(tx), .tx_busy(tx_busy)
    );

    int checks = 0, errors = 0, cyc = 0, busy_n = 0;
    logic [15:0] rd_last = '0;
    logic [7:0]  q[$];
    logic        act = 1'b0, ovf = 1'b0;
    int          s = 0;
    logic [7:0]  b = '0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Line level at an edge follows from frame start time: start, 8 data LSB first, stop.
    function automatic logic exp_tx();
        int k;
        if (!act) return 1'b1;
        k = (cyc - s) / D;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    function automatic logic [15:0] exp_rd(input logic [19:0] a);
        if (a == STAT) return {7'b0, 5'(q.size()), ovf, act, q.size() == N, q.size() == 0};
        if (a == BASE) return 16'h0000;
        return FLOAT;
    endfunction

    task automatic model_reset();
        q.delete();
        act = 1'b0;
        ovf = 1'b0;
        s = 0;
    endtask

    task automatic model_edge(input logic we, input logic re, input logic [19:0] a, input logic [15:0] d);
        logic full0;
        full0 = q.size() == N;
        if (act && cyc - s == 10 * D) begin
            if (q.size() != 0) begin
                b = q.pop_front();
                s = cyc;
            end else act = 1'b0;
        end else if (!act && q.size() != 0) begin
            b = q.pop_front();
            s = cyc;
            act = 1'b1;
        end
        if (we && a == BASE && full0) ovf = 1'b1;
        else if (re && a == STAT) ovf = 1'b0;
        if (we && a == BASE && !full0) q.push_back(d[7:0]);
    endtask

    task automatic tick(input logic we, input logic re, input logic [19:0] a, input logic [15:0] d);
        mem_write = we;
        mem_read  = re;
        bus_addr  = a;
        drv       = d;
        drv_en    = we;
        #1;
        if (!we) begin
            rd_last = bus_data;
            chk("bus", bus_data, re ? exp_rd(a) : FLOAT);
        end
        @(posedge clk);
        #1;
        cyc++;
        model_edge(we, re, a, d);
        chk("tx", {15'b0, tx}, {15'b0, exp_tx()});
        chk("busy", {15'b0, tx_busy}, {15'b0, act});
        if (tx_busy) busy_n++;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        drv_en    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 20'h0, 16'h0);
    endtask

    initial begin
        logic [9:0]  pat;
        logic [19:0] a;
        logic [2:0]  sel;
        pat = 10'b1101001010;
        #12;
        chk("rst_tx", {15'b0, tx}, 16'h0001);
        chk("rst_busy", {15'b0, tx_busy}, 16'h0000);
        chk("rst_bus", bus_data, FLOAT);
        reset = 1'b1;
        model_reset();
        idle(3);
        tick(1'b0, 1'b1, STAT, 16'h0);
        chk("status_idle", rd_last, 16'h0001);
        tick(1'b0, 1'b1, BASE, 16'h0);
        chk("data_read", rd_last, 16'h0000);

        busy_n = 0;
        tick(1'b1, 1'b0, BASE, 16'h3CA5);
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b0, 20'h0, 16'h0);
            chk("a5_line", {15'b0, tx}, {15'b0, pat[i/4]});
        end
        idle(5);
        chk("a5_busy_len", 16'(busy_n), 16'd40);

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, BASE, 16'($urandom));
        idle(130);
        tick(1'b0, 1'b1, STAT, 16'h0);
        chk("status_after3", rd_last, 16'h0001);

        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, BASE, 16'($urandom));
        tick(1'b0, 1'b1, STAT, 16'h0);
        chk("ovf_set", {15'b0, rd_last[3]}, 16'h0001);
        chk("ovf_full", {15'b0, rd_last[1]}, 16'h0001);
        chk("ovf_count", {11'b0, rd_last[8:4]}, 16'd4);
        tick(1'b0, 1'b1, STAT, 16'h0);
        chk("ovf_clear", {15'b0, rd_last[3]}, 16'h0000);
        idle(220);

        for (int i = 0; i < 60; i++) begin
            sel = 3'($urandom_range(0, 5));
            a = (sel == 0) ? BASE : (sel == 1) ? STAT : (sel == 2) ? BASE + 20'd2 :
                (sel == 3) ? BASE - 20'd1 : (sel == 4) ? BASE ^ 20'h10000 : 20'($urandom);
            tick(1'b0, ($urandom_range(0, 1) == 1), a, 16'h0);
        end

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, BASE, 16'($urandom));
        idle(13);
        #3 reset = 1'b0;
        #1;
        chk("abort_tx", {15'b0, tx}, 16'h0001);
        chk("abort_busy", {15'b0, tx_busy}, 16'h0000);
        model_reset();
        #2 reset = 1'b1;
        tick(1'b0, 1'b1, STAT, 16'h0);
        chk("abort_status", rd_last, 16'h0001);
        idle(50);

        for (int i = 0; i < 1500; i++) begin
            sel = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? BASE + 20'($urandom_range(0, 3)) - 20'd1
                                            : (($urandom_range(0, 1) == 1) ? BASE : STAT);
            if (sel == 0) tick(1'b1, 1'b0, a, 16'($urandom));
            else if (sel == 1) tick(1'b0, 1'b1, a, 16'h0);
            else tick(1'b0, 1'b0, a, 16'h0);
        end
        idle(250);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
